// File: rtl/mat_operand_seq.sv
// mat_operand_seq
// Operand sequencer for mat_mult. Holds a 4x4 X matrix (unsigned, A_W bits)
// and a 4x4 Y matrix (signed Q0.7, B_W bits) written through one write port.
// A start pulse streams the 16 (i,j) operand sets: A0n = X[i][n], Bn = Y[n][j].
//
// Build option: define OPSEQ_COLMAJOR_EN for column-major order (j outer,
// i inner). Without it the order is row-major (i outer, j inner).
//
// Ports:
//   clk_80, rst_80          clock (rising edge), synchronous active-high reset
//   wr_en_80, wr_sel_80     write strobe, 0 = X / 1 = Y
//   wr_row_80, wr_col_80    element address
//   wr_data_80              write data (Y uses the low B_W bits)
//   start_80                begin a 16-set stream (honoured only in IDLE)
//   stall_80                downstream hold, freezes the stream
//   busy_80                 high while streaming
//   A00_80..A03_80          X row i of the current set
//   B00_80..B03_80          Y column j of the current set
//   op_valid_80             operand set valid
//   op_row_80, op_col_80    (i,j) tag of the current set
//   op_last_80              high while set (3,3) is presented
//   done_80                 one-cycle pulse after set (3,3) is consumed
module mat_operand_seq #(
  parameter int A_W = 9,
  parameter int B_W = 8
) (
  input  logic           clk_80,
  input  logic           rst_80,
  input  logic           wr_en_80,
  input  logic           wr_sel_80,
  input  logic [1:0]     wr_row_80,
  input  logic [1:0]     wr_col_80,
  input  logic [A_W-1:0] wr_data_80,
  input  logic           start_80,
  input  logic           stall_80,
  output logic           busy_80,
  output logic [A_W-1:0] A00_80,
  output logic [A_W-1:0] A01_80,
  output logic [A_W-1:0] A02_80,
  output logic [A_W-1:0] A03_80,
  output logic [B_W-1:0] B00_80,
  output logic [B_W-1:0] B01_80,
  output logic [B_W-1:0] B02_80,
  output logic [B_W-1:0] B03_80,
  output logic           op_valid_80,
  output logic [1:0]     op_row_80,
  output logic [1:0]     op_col_80,
  output logic           op_last_80,
  output logic           done_80
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t state_reg, state_next;

  // Storage must clear on reset, so it is kept in registers rather than RAM.
  logic [A_W-1:0] x_mem [4][4];
  logic [B_W-1:0] y_mem [4][4];

  logic [1:0]     row_reg, col_reg, row_next, col_next;
  logic [A_W-1:0] a_reg [4];
  logic [B_W-1:0] b_reg [4];
  logic [A_W-1:0] a_sel [4];
  logic [B_W-1:0] b_sel [4];
  logic           valid_reg, last_reg, busy_reg, done_reg;
  logic           load_set, clear_set;

  // Operand lanes for the set that will be presented after this edge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign a_sel[gi] = x_mem[row_next][gi];
      assign b_sel[gi] = y_mem[gi][col_next];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    load_set   = 1'b0;
    clear_set  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_80) begin
          state_next = STREAM;
          row_next   = 2'd0;
          col_next   = 2'd0;
          load_set   = 1'b1;
        end
      end
      STREAM: begin
        if (!stall_80) begin
          if (row_reg == 2'd3 && col_reg == 2'd3) begin
            state_next = DONE;
            row_next   = 2'd0;
            col_next   = 2'd0;
            clear_set  = 1'b1;
          end else begin
            load_set = 1'b1;
`ifdef OPSEQ_COLMAJOR_EN
            if (row_reg == 2'd3) begin
              row_next = 2'd0;
              col_next = col_reg + 2'd1;
            end else begin
              row_next = row_reg + 2'd1;
            end
`else
            if (col_reg == 2'd3) begin
              col_next = 2'd0;
              row_next = row_reg + 2'd1;
            end else begin
              col_next = col_reg + 2'd1;
            end
`endif
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        a_reg[r] <= '0;
        b_reg[r] <= '0;
        for (int c = 0; c < 4; c++) begin
          x_mem[r][c] <= '0;
          y_mem[r][c] <= '0;
        end
      end
    end else begin
      // Storage is frozen during a run; a write coinciding with start lands
      // after the first set has already sampled the old contents.
      if (wr_en_80 && state_reg != STREAM) begin
        if (wr_sel_80) begin
          y_mem[wr_row_80][wr_col_80] <= wr_data_80[B_W-1:0];
        end else begin
          x_mem[wr_row_80][wr_col_80] <= wr_data_80;
        end
      end
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      busy_reg  <= (state_next == STREAM);
      valid_reg <= (state_next == STREAM);
      done_reg  <= (state_next == DONE);
      if (load_set) begin
        last_reg <= (row_next == 2'd3) && (col_next == 2'd3);
      end else if (clear_set) begin
        last_reg <= 1'b0;
      end
      for (int n = 0; n < 4; n++) begin
        if (load_set) begin
          a_reg[n] <= a_sel[n];
          b_reg[n] <= b_sel[n];
        end else if (clear_set) begin
          a_reg[n] <= '0;
          b_reg[n] <= '0;
        end
      end
    end
  end

  assign busy_80     = busy_reg;
  assign op_valid_80 = valid_reg;
  assign op_row_80   = row_reg;
  assign op_col_80   = col_reg;
  assign op_last_80  = last_reg;
  assign done_80     = done_reg;
  assign A00_80      = a_reg[0];
  assign A01_80      = a_reg[1];
  assign A02_80      = a_reg[2];
  assign A03_80      = a_reg[3];
  assign B00_80      = b_reg[0];
  assign B01_80      = b_reg[1];
  assign B02_80      = b_reg[2];
  assign B03_80      = b_reg[3];

endmodule

// File: tb/tb_mat_operand_seq.sv
// tb_mat_operand_seq
// Self-checking bench for mat_operand_seq. The stimulus block loads X/Y,
// starts streams and pushes the expected operand sets into a queue; a
// negedge monitor pops and compares each consumed set. Honours
// OPSEQ_COLMAJOR_EN for the expected ordering.
module tb_mat_operand_seq;
  localparam int A_W = 9;
  localparam int B_W = 8;

  logic           clk_80 = 1'b0;
  logic           rst_80 = 1'b1;
  logic           wr_en_80 = 1'b0;
  logic           wr_sel_80 = 1'b0;
  logic [1:0]     wr_row_80 = '0;
  logic [1:0]     wr_col_80 = '0;
  logic [A_W-1:0] wr_data_80 = '0;
  logic           start_80 = 1'b0;
  logic           stall_80 = 1'b0;
  logic           busy_80;
  logic [A_W-1:0] A00_80, A01_80, A02_80, A03_80;
  logic [B_W-1:0] B00_80, B01_80, B02_80, B03_80;
  logic           op_valid_80;
  logic [1:0]     op_row_80, op_col_80;
  logic           op_last_80;
  logic           done_80;

  mat_operand_seq #(.A_W(A_W), .B_W(B_W)) dut (
    .clk_80(clk_80), .rst_80(rst_80),
    .wr_en_80(wr_en_80), .wr_sel_80(wr_sel_80),
    .wr_row_80(wr_row_80), .wr_col_80(wr_col_80), .wr_data_80(wr_data_80),
    .start_80(start_80), .stall_80(stall_80), .busy_80(busy_80),
    .A00_80(A00_80), .A01_80(A01_80), .A02_80(A02_80), .A03_80(A03_80),
    .B00_80(B00_80), .B01_80(B01_80), .B02_80(B02_80), .B03_80(B03_80),
    .op_valid_80(op_valid_80), .op_row_80(op_row_80), .op_col_80(op_col_80),
    .op_last_80(op_last_80), .done_80(done_80)
  );

  always #5 clk_80 = ~clk_80;

  typedef struct packed {
    logic [3:0][A_W-1:0] a;
    logic [3:0][B_W-1:0] b;
    logic [1:0]          r;
    logic [1:0]          c;
    logic                last;
  } set_t;

  localparam int XV [4][4] = '{'{10, 20, 30, 40}, '{50, 60, 70, 80},
                               '{90, 100, 110, 120}, '{130, 140, 150, 160}};
  // YC[j][n] is column j of Y, i.e. Y[n][j].
  localparam int YC [4][4] = '{'{13, 77, 102, 205}, '{26, 166, 90, 38},
                               '{38, 154, 77, 230}, '{192, 115, 64, 13}};

  set_t           exp_q[$];
  set_t           mon_e;
  logic [A_W-1:0] x_m [4][4];
  logic [B_W-1:0] y_m [4][4];
  int             total = 0;
  int             bad = 0;
  int             valid_cnt = 0;
  int             done_cnt = 0;

  wire [4*A_W-1:0] obs_a = {A03_80, A02_80, A01_80, A00_80};
  wire [4*B_W-1:0] obs_b = {B03_80, B02_80, B01_80, B00_80};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_80);
    #1;
  endtask

  function automatic int pos_r(input int k);
`ifdef OPSEQ_COLMAJOR_EN
    return k % 4;
`else
    return k / 4;
`endif
  endfunction

  function automatic int pos_c(input int k);
`ifdef OPSEQ_COLMAJOR_EN
    return k / 4;
`else
    return k % 4;
`endif
  endfunction

  function automatic set_t mk(input int r, input int c);
    set_t s;
    for (int n = 0; n < 4; n++) begin
      s.a[n] = x_m[r][n];
      s.b[n] = y_m[n][c];
    end
    s.r    = r[1:0];
    s.c    = c[1:0];
    s.last = (r == 3) && (c == 3);
    return s;
  endfunction

  // Compare every presented set; pop only when it is consumed (no stall).
  always @(negedge clk_80) begin
    if (!rst_80) begin
      if (done_80) done_cnt++;
      if (op_valid_80) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL extra_set observed=(%0d,%0d) expected=no set", op_row_80, op_col_80);
        end else begin
          mon_e = exp_q[0];
          chk("a_ops", obs_a, mon_e.a);
          chk("b_ops", obs_b, mon_e.b);
          chk("tag", {op_row_80, op_col_80, op_last_80}, {mon_e.r, mon_e.c, mon_e.last});
          if (!stall_80) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_zero", {obs_a, obs_b, op_row_80, op_col_80, op_last_80}, '0);
      end
    end
  end

  task automatic wr(input bit sel, input int r, input int c, input int v);
    wr_en_80   = 1'b1;
    wr_sel_80  = sel;
    wr_row_80  = r[1:0];
    wr_col_80  = c[1:0];
    wr_data_80 = v[A_W-1:0];
    step();
    wr_en_80 = 1'b0;
    if (sel) y_m[r][c] = v[B_W-1:0];
    else     x_m[r][c] = v[A_W-1:0];
  endtask

  task automatic run(input string nm, input int stall_n, input bit restart,
                     input bit wr_mid, input bit wr_start, input int a00_exp,
                     input int exp_valid);
    int stall_left;
    bit seen;
    stall_left = stall_n;
    seen       = 1'b0;
    valid_cnt  = 0;
    done_cnt   = 0;
    start_80   = 1'b1;
    exp_q.push_back(mk(pos_r(0), pos_c(0)));
    if (wr_start) begin
      wr_en_80   = 1'b1;
      wr_sel_80  = 1'b0;
      wr_row_80  = 2'd0;
      wr_col_80  = 2'd1;
      wr_data_80 = 9'd7;
      x_m[0][1]  = 9'd7;
    end
    for (int k = 1; k < 16; k++) exp_q.push_back(mk(pos_r(k), pos_c(k)));
    step();
    start_80 = 1'b0;
    wr_en_80 = 1'b0;
    chk({nm, "_latency"}, {op_valid_80, busy_80}, 2'b11);
    if (a00_exp >= 0) chk({nm, "_a00_first"}, A00_80, a00_exp[A_W-1:0]);
    for (int s = 0; s < 60; s++) begin
      if (done_80) begin
        seen = 1'b1;
        break;
      end
      stall_80 = (stall_left > 0) && op_valid_80 && (op_row_80 == 2'd0) && (op_col_80 == 2'd2);
      if (stall_80) stall_left--;
      start_80 = restart && (s == 4);
      if (wr_mid && s == 3) begin
        wr_en_80   = 1'b1;
        wr_sel_80  = 1'b0;
        wr_row_80  = 2'd0;
        wr_col_80  = 2'd0;
        wr_data_80 = 9'd511;
      end else begin
        wr_en_80 = 1'b0;
      end
      step();
    end
    chk({nm, "_done_seen"}, seen, 1'b1);
    chk({nm, "_done_state"}, {op_valid_80, busy_80, op_last_80, obs_a, obs_b}, '0);
    stall_80 = 1'b0;
    wr_en_80 = 1'b0;
    start_80 = 1'b1;  // sampled in DONE, must be ignored
    step();
    start_80 = 1'b0;
    chk({nm, "_done_one_cycle"}, done_80, 1'b0);
    chk({nm, "_start_in_done"}, {op_valid_80, busy_80}, 2'b00);
    chk({nm, "_valid_cycles"}, valid_cnt, exp_valid);
    chk({nm, "_done_count"}, done_cnt, 1);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    $display("run %s: valid_cycles=%0d done_pulses=%0d", nm, valid_cnt, done_cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        x_m[r][c] = '0;
        y_m[r][c] = '0;
      end
    end
    // Reset dominates a simultaneous start.
    rst_80   = 1'b1;
    start_80 = 1'b1;
    step();
    step();
    start_80 = 1'b0;
    chk("rst_ctrl", {busy_80, op_valid_80, op_last_80, done_80}, 4'b0);
    chk("rst_ops", {obs_a, obs_b, op_row_80, op_col_80}, '0);
    rst_80 = 1'b0;
    step();
    chk("idle_after_rst", {busy_80, op_valid_80}, 2'b00);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wr(1'b0, r, c, XV[r][c]);
    for (int j = 0; j < 4; j++)
      for (int n = 0; n < 4; n++) wr(1'b1, n, j, YC[j][n]);

    run("basic",    0, 1'b0, 1'b0, 1'b0, 10, 16);
    run("stall",    3, 1'b0, 1'b0, 1'b0, -1, 19);
    run("wr_mid",   0, 1'b0, 1'b1, 1'b0, -1, 16);
    run("after_wr", 0, 1'b0, 1'b0, 1'b0, 10, 16);
    run("restart",  0, 1'b1, 1'b0, 1'b0, -1, 16);
    run("wr_start", 0, 1'b0, 1'b0, 1'b1, 10, 16);

    // Reset while (1,2) is presented.
    start_80 = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(mk(pos_r(k), pos_c(k)));
    step();
    start_80 = 1'b0;
    found = 1'b0;
    for (int s = 0; s < 40; s++) begin
      if (op_valid_80 && op_row_80 == 2'd1 && op_col_80 == 2'd2) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("reach_set_1_2", found, 1'b1);
    rst_80   = 1'b1;
    done_cnt = 0;
    step();
    chk("midrst_ctrl", {busy_80, op_valid_80, op_last_80, done_80}, 4'b0);
    chk("midrst_ops", {obs_a, obs_b, op_row_80, op_col_80}, '0);
    rst_80 = 1'b0;
    exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        x_m[r][c] = '0;
        y_m[r][c] = '0;
      end
    end
    repeat (3) step();
    chk("midrst_no_done", done_cnt, 0);
    $display("run midrst: reset applied at set (1,2)");

    run("zeros", 0, 1'b0, 1'b0, 1'b0, 0, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
